pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: width of PC and all target buses.
REQ-002 Parameter INST_BYTES, default 4: sequential increment; power of two, 1..8.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-004 Parameter EXC_VECTOR, default 32'h0000_0004: exception redirect target.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 stall_i  in  1  pipeline stall from hazard unit; blocks PC advance.
REQ-009 if_ready_i  in  1  instruction memory accepts the current fetch address.
REQ-010 exc_i  in  1  exception redirect request, single-cycle pulse.
REQ-011 br_taken_i  in  1  taken-branch redirect request, single-cycle pulse.
REQ-012 br_target_i  in  XLEN  branch target.
REQ-013 jmp_i  in  1  jump redirect request, single-cycle pulse.
REQ-014 jmp_target_i  in  XLEN  jump target.
REQ-015 pc_o  out  XLEN  current fetch address (registered).
REQ-016 pc_plus_o  out  XLEN  pc_o + INST_BYTES, combinational, modulo 2^XLEN.
REQ-017 fetch_valid_o  out  1  pc_o is a valid fetch address.
REQ-018 flush_o  out  1  a redirect is being applied this cycle; younger stages flush.
REQ-019 pend_o  out  1  a redirect is held pending (HOLD state).

Function
REQ-020 Advance condition: adv = !stall_i && if_ready_i.
REQ-021 Same-cycle request priority: exc_i > br_taken_i > jmp_i; the selected target is EXC_VECTOR, br_target_i or jmp_target_i respectively.
REQ-022 Every target has its low log2(INST_BYTES) bits cleared before use.
REQ-023 States: RUN (no pending redirect), HOLD (pending target register valid).
REQ-024 RUN, adv, request present: pc_o <= selected target next edge; flush_o = 1 this cycle; stay RUN.
REQ-025 RUN, adv, no request: pc_o <= pc_o + INST_BYTES, wrapping modulo 2^XLEN; flush_o = 0.
REQ-026 RUN, !adv, request present: latch selected target and its exception flag; go HOLD; pc_o unchanged; flush_o = 0.
REQ-027 RUN, !adv, no request: pc_o, state unchanged.
REQ-028 HOLD, !adv: a new request overwrites the pending target unless the pending entry is an exception and the new one is not; pc_o unchanged.
REQ-029 HOLD, adv: pc_o <= pending target (or the new request's target under the REQ-028 overwrite rule); flush_o = 1; go RUN.
REQ-030 pend_o = 1 exactly in HOLD.
REQ-031 fetch_valid_o = 1 in every cycle after reset release except the cycle immediately following reset deassertion, when it is 0.
REQ-032 pc_o never changes in a cycle where adv = 0.
REQ-033 flush_o is combinational and asserts only when pc_o loads a redirect target on the next edge.

Reset
REQ-034 rst_n low asynchronously forces pc_o = RESET_PC, state RUN, pending register cleared, fetch_valid_o = 0, flush_o = 0.
REQ-035 Reset asserted while in HOLD discards the pending redirect; no flush follows release.
REQ-036 Requests during reset are ignored.

Verification
REQ-037 Reset release, adv=1 for 4 cycles, XLEN=32, INST_BYTES=4 -> pc_o 0x0,0x4,0x8,0xC; fetch_valid_o 0 then 1.
REQ-038 pc_o=0xFFFF_FFFC, adv=1 -> next pc_o=0x0000_0000; pc_plus_o at 0xFFFF_FFFC reads 0x0.
REQ-039 exc_i, br_taken_i (0x100), jmp_i (0x200) in one adv cycle -> flush_o=1, next pc_o=0x4 (EXC_VECTOR).
REQ-040 stall_i=1, br_taken_i to 0x80 -> pend_o=1, pc_o held 3 stall cycles; stall released -> flush_o=1, pc_o=0x80, pend_o=0.
REQ-041 HOLD with pending exception, jmp_i to 0x40 -> pending stays EXC_VECTOR; jmp_target_i 0x43 in RUN -> pc_o=0x40.
REQ-042 rst_n pulsed low while pend_o=1 -> pc_o=RESET_PC immediately, pend_o=0, no flush_o after release.

Source files
------------

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-PC bus between the PC generator and its neighbours.
//   Requests into the generator: stall_i, if_ready_i, exc_i, br_taken_i/br_target_i,
//   jmp_i/jmp_target_i.
//   Fetch state out of the generator: pc_o, pc_plus_o, fetch_valid_o, flush_o, pend_o.
//   slave  : the PC generator side.
//   master : the pipeline/driver side.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            if_ready_i;
  logic            exc_i;
  logic            br_taken_i;
  logic [XLEN-1:0] br_target_i;
  logic            jmp_i;
  logic [XLEN-1:0] jmp_target_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_plus_o;
  logic            fetch_valid_o;
  logic            flush_o;
  logic            pend_o;

  modport slave (
    input  stall_i, if_ready_i, exc_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
    output pc_o, pc_plus_o, fetch_valid_o, flush_o, pend_o
  );

  modport master (
    output stall_i, if_ready_i, exc_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
    input  pc_o, pc_plus_o, fetch_valid_o, flush_o, pend_o
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
//   Advances the PC by INST_BYTES whenever the front end can move (not stalled and
//   instruction memory ready). Exception / branch / jump redirects are applied
//   immediately when the PC can move, otherwise parked in a single pending slot
//   (HOLD state) until it can. A pending exception is never displaced by a
//   lower-priority redirect.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - pc_gen_if slave modport (requests in, PC / flush / pending out)
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter int              INST_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0004
) (
  input  logic    clk,
  input  logic    rst_n,
  pc_gen_if.slave bus
);

  // Clears the low log2(INST_BYTES) bits of every redirect target.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));
  localparam logic [XLEN-1:0] INC        = XLEN'(INST_BYTES);

  typedef enum logic {RUN, HOLD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_exc_q, pend_exc_d;
  logic            fetch_vld_q;

  logic            adv;
  logic            req;
  logic [XLEN-1:0] req_tgt;
  logic            take_new;
  logic            flush;

  assign adv = !bus.stall_i && bus.if_ready_i;
  assign req = bus.exc_i || bus.br_taken_i || bus.jmp_i;

  // Same-cycle priority: exception, then branch, then jump.
  always_comb begin
    if (bus.exc_i)           req_tgt = EXC_VECTOR & ALIGN_MASK;
    else if (bus.br_taken_i) req_tgt = bus.br_target_i & ALIGN_MASK;
    else                     req_tgt = bus.jmp_target_i & ALIGN_MASK;
  end

  // In HOLD a new request replaces the pending one, except that a pending
  // exception can only be replaced by another exception.
  assign take_new = req && !(pend_exc_q && !bus.exc_i);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_exc_d = pend_exc_q;
    flush      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (req && adv) begin
          pc_d  = req_tgt;
          flush = 1'b1;
        end else if (req) begin
          pend_tgt_d = req_tgt;
          pend_exc_d = bus.exc_i;
          state_d    = HOLD;
        end else if (adv) begin
          pc_d = pc_q + INC;
        end
      end
      HOLD: begin
        if (adv) begin
          pc_d       = take_new ? req_tgt : pend_tgt_q;
          flush      = 1'b1;
          pend_tgt_d = '0;
          pend_exc_d = 1'b0;
          state_d    = RUN;
        end else if (take_new) begin
          pend_tgt_d = req_tgt;
          pend_exc_d = bus.exc_i;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      pend_tgt_q  <= '0;
      pend_exc_q  <= 1'b0;
      fetch_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_exc_q  <= pend_exc_d;
      fetch_vld_q <= 1'b1;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.pc_plus_o     = pc_q + INC;
  assign bus.fetch_valid_o = fetch_vld_q;
  // Requests seen while reset is held must not report a flush.
  assign bus.flush_o       = flush && rst_n;
  assign bus.pend_o        = (state_q == HOLD);

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed table-driven bench for pc_gen (XLEN=32, INST_BYTES=4,
// RESET_PC=0, EXC_VECTOR=4) plus hand-written reset sequences.
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN(32), .INST_BYTES(4), .RESET_PC(32'h0), .EXC_VECTOR(32'h4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rdy;
    logic        exc;
    logic        br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jt;
    logic        fl;    // flush_o during the applied cycle
    logic [31:0] pc;    // pc_o after the edge
    logic        pd;    // pend_o after the edge
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic stall, logic rdy, logic exc, logic br, logic [31:0] brt,
                              logic jmp, logic [31:0] jt, logic fl, logic [31:0] pc, logic pd);
    vec_t v;
    v.stall = stall; v.rdy = rdy; v.exc = exc; v.br = br; v.brt = brt;
    v.jmp = jmp; v.jt = jt; v.fl = fl; v.pc = pc; v.pd = pd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic stall, logic rdy, logic exc, logic br, logic [31:0] brt,
                       logic jmp, logic [31:0] jt);
    bus.stall_i = stall; bus.if_ready_i = rdy; bus.exc_i = exc;
    bus.br_taken_i = br; bus.br_target_i = brt; bus.jmp_i = jmp; bus.jmp_target_i = jt;
  endtask

  initial begin
    //          stall rdy exc br  brt           jmp jt            fl  pc            pd
    tbl[0]  = mk(0,   1,  0,  0,  32'h0,        0,  32'h0,        0,  32'h4,        0);
    tbl[1]  = mk(0,   1,  0,  0,  32'h0,        0,  32'h0,        0,  32'h8,        0);
    tbl[2]  = mk(0,   1,  0,  0,  32'h0,        0,  32'h0,        0,  32'hC,        0);
    tbl[3]  = mk(0,   1,  1,  1,  32'h100,      1,  32'h200,      1,  32'h4,        0);
    tbl[4]  = mk(0,   1,  0,  0,  32'h0,        1,  32'hFFFF_FFFC,1,  32'hFFFF_FFFC,0);
    tbl[5]  = mk(0,   1,  0,  0,  32'h0,        0,  32'h0,        0,  32'h0,        0);
    tbl[6]  = mk(1,   1,  0,  1,  32'h80,       0,  32'h0,        0,  32'h0,        1);
    tbl[7]  = mk(1,   1,  0,  0,  32'h0,        0,  32'h0,        0,  32'h0,        1);
    tbl[8]  = mk(1,   1,  0,  0,  32'h0,        0,  32'h0,        0,  32'h0,        1);
    tbl[9]  = mk(0,   1,  0,  0,  32'h0,        0,  32'h0,        1,  32'h80,       0);
    tbl[10] = mk(0,   0,  1,  0,  32'h0,        0,  32'h0,        0,  32'h80,       1);
    tbl[11] = mk(0,   0,  0,  0,  32'h0,        1,  32'h40,       0,  32'h80,       1);
    tbl[12] = mk(0,   1,  0,  0,  32'h0,        0,  32'h0,        1,  32'h4,        0);
    tbl[13] = mk(0,   1,  0,  0,  32'h0,        1,  32'h43,       1,  32'h40,       0);
    tbl[14] = mk(0,   1,  0,  1,  32'h107,      0,  32'h0,        1,  32'h104,      0);
    tbl[15] = mk(1,   1,  0,  0,  32'h0,        1,  32'h300,      0,  32'h104,      1);
    tbl[16] = mk(1,   1,  0,  1,  32'h500,      0,  32'h0,        0,  32'h104,      1);
    tbl[17] = mk(0,   1,  0,  0,  32'h0,        1,  32'h600,      1,  32'h600,      0);
    tbl[18] = mk(0,   0,  0,  0,  32'h0,        1,  32'h700,      0,  32'h600,      1);
    tbl[19] = mk(1,   0,  1,  0,  32'h0,        0,  32'h0,        0,  32'h600,      1);
    tbl[20] = mk(0,   1,  0,  0,  32'h0,        0,  32'h0,        1,  32'h4,        0);
    tbl[21] = mk(1,   1,  0,  0,  32'h0,        0,  32'h0,        0,  32'h4,        0);

    // Reset with requests active: they must be ignored.
    rst_n = 1'b0;
    drive(0, 1, 1, 1, 32'h100, 1, 32'h200);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", bus.pc_o, 32'h0);
    chk("rst_fv", {31'b0, bus.fetch_valid_o}, 32'h0);
    chk("rst_flush", {31'b0, bus.flush_o}, 32'h0);
    chk("rst_pend", {31'b0, bus.pend_o}, 32'h0);

    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_fv", {31'b0, bus.fetch_valid_o}, 32'h0);
    chk("rel_pc", bus.pc_o, 32'h0);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].stall, tbl[i].rdy, tbl[i].exc, tbl[i].br, tbl[i].brt, tbl[i].jmp, tbl[i].jt);
      #1;
      chk($sformatf("v%0d_flush", i), {31'b0, bus.flush_o}, {31'b0, tbl[i].fl});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i), bus.pc_o, tbl[i].pc);
      chk($sformatf("v%0d_plus", i), bus.pc_plus_o, tbl[i].pc + 32'd4);
      chk($sformatf("v%0d_pend", i), {31'b0, bus.pend_o}, {31'b0, tbl[i].pd});
      chk($sformatf("v%0d_fv", i), {31'b0, bus.fetch_valid_o}, 32'h1);
      @(negedge clk);
    end

    // Wrap boundary: pc_plus at 0xFFFF_FFFC reads 0.
    drive(0, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap_plus", bus.pc_plus_o, 32'h0);
    @(negedge clk);

    // Reset pulsed mid-cycle while a redirect is pending.
    drive(1, 1, 0, 1, 32'h80, 0, 32'h0);
    @(posedge clk); #1;
    chk("hold_pend", {31'b0, bus.pend_o}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", bus.pc_o, 32'h0);
    chk("arst_pend", {31'b0, bus.pend_o}, 32'h0);
    chk("arst_fv", {31'b0, bus.fetch_valid_o}, 32'h0);
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("arel_flush", {31'b0, bus.flush_o}, 32'h0);
    chk("arel_fv", {31'b0, bus.fetch_valid_o}, 32'h0);
    @(posedge clk); #1;
    chk("arel_pc", bus.pc_o, 32'h4);
    chk("arel_pend", {31'b0, bus.pend_o}, 32'h0);
    chk("arel_fv1", {31'b0, bus.fetch_valid_o}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
